// File: rtl/lift_call_scheduler.sv
// Call-button scheduler for a four-floor lift: latches calls, picks the next floor
// with a SCAN rule, drives the requested floor and holds a door dwell on arrival.
module lift_call_scheduler #(
  parameter int DWELL_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] call_btn,
  input  logic       gndF,
  input  logic       fstF,
  input  logic       sndF,
  input  logic       trdF,
  output logic [1:0] req_floor,
  output logic [3:0] pending,
  output logic       door_open,
  output logic       busy,
  output logic       floor_err,
  output logic       timeout_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_DWELL = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);
  localparam logic [7:0] TMO_LOAD   = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic [1:0] req_q, req_d;
  logic [3:0] pend_q, pend_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] dwell_q, dwell_d;
  logic [1:0] dfloor_q, dfloor_d;
  logic       ferr_q;
  logic       terr_q, terr_d;

  logic [3:0] ind;
  logic       ind_ok;
  logic [1:0] cf;
  logic [3:0] cand;
  logic       up_hit, dn_hit;
  logic [1:0] up_fl, dn_fl;
  logic [1:0] tgt;
  logic       tgt_dir;
  logic [3:0] btn_mask;
  logic [3:0] clr;

  assign ind    = {trdF, sndF, fstF, gndF};
  assign ind_ok = (ind == 4'b0001) || (ind == 4'b0010) ||
                  (ind == 4'b0100) || (ind == 4'b1000);

  always_comb begin
    case (ind)
      4'b0010: cf = 2'd1;
      4'b0100: cf = 2'd2;
      4'b1000: cf = 2'd3;
      default: cf = 2'd0;
    endcase
  end

  // The current floor is never a SCAN candidate; IDLE serves it directly.
  assign cand = pend_q & ~(4'b0001 << cf);

  always_comb begin
    up_hit = 1'b0;
    up_fl  = 2'd0;
    dn_hit = 1'b0;
    dn_fl  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i] && (i > int'(cf))) begin
        up_hit = 1'b1;
        up_fl  = i[1:0];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (cand[i] && (i < int'(cf))) begin
        dn_hit = 1'b1;
        dn_fl  = i[1:0];
      end
    end
  end

  always_comb begin
    tgt     = 2'd0;
    tgt_dir = dir_q;
    if (dir_q == DIR_UP) begin
      if (up_hit) tgt = up_fl;
      else begin
        tgt     = dn_fl;
        tgt_dir = DIR_DOWN;
      end
    end else begin
      if (dn_hit) tgt = dn_fl;
      else begin
        tgt     = up_fl;
        tgt_dir = DIR_UP;
      end
    end
  end

  // The floor whose door is open does not re-latch its own button.
  always_comb begin
    btn_mask = 4'b1111;
    if (state_q == S_DWELL) btn_mask = ~(4'b0001 << dfloor_q);
  end

  // A bad indicator pattern freezes the whole FSM, timers included.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    req_d    = req_q;
    tmo_d    = tmo_q;
    dwell_d  = dwell_q;
    dfloor_d = dfloor_q;
    clr      = 4'b0000;
    terr_d   = 1'b0;
    if (ind_ok) begin
      case (state_q)
        S_IDLE: begin
          if (pend_q[cf]) begin
            clr      = 4'b0001 << cf;
            dfloor_d = cf;
            dwell_d  = DWELL_LOAD;
            state_d  = S_DWELL;
          end else if (pend_q != 4'b0000) begin
            req_d   = tgt;
            dir_d   = tgt_dir;
            tmo_d   = TMO_LOAD;
            state_d = S_MOVE;
          end
        end
        S_MOVE: begin
          if (cf == req_q) begin
            clr      = 4'b0001 << cf;
            dfloor_d = cf;
            dwell_d  = DWELL_LOAD;
            state_d  = S_DWELL;
          end else if (tmo_q == 8'd0) begin
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q - 8'd1;
          end
        end
        S_DWELL: begin
          if (dwell_q == 8'd0) state_d = S_IDLE;
          else dwell_d = dwell_q - 8'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign pend_d = (pend_q | (call_btn & btn_mask)) & ~clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      dir_q    <= DIR_UP;
      req_q    <= 2'd0;
      pend_q   <= 4'b0000;
      tmo_q    <= 8'd0;
      dwell_q  <= 8'd0;
      dfloor_q <= 2'd0;
      ferr_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      req_q    <= req_d;
      pend_q   <= pend_d;
      tmo_q    <= tmo_d;
      dwell_q  <= dwell_d;
      dfloor_q <= dfloor_d;
      ferr_q   <= ~ind_ok;
      terr_q   <= terr_d;
    end
  end

  assign req_floor   = req_q;
  assign pending     = pend_q;
  assign door_open   = (state_q == S_DWELL);
  assign busy        = (state_q != S_IDLE);
  assign floor_err   = ferr_q;
  assign timeout_err = terr_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler: expected output words are queued with
// each driven cycle and compared one time unit after the following rising edge.
module tb_lift_call_scheduler;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] M = 2'd1;
  localparam logic [1:0] D = 2'd2;

  logic       clk;
  logic       rst;
  logic [3:0] call_btn;
  logic       gndF, fstF, sndF, trdF;
  logic [1:0] req_floor;
  logic [3:0] pending;
  logic       door_open, busy, floor_err, timeout_err;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  lift_call_scheduler #(.DWELL_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .call_btn    (call_btn),
    .gndF        (gndF),
    .fstF        (fstF),
    .sndF        (sndF),
    .trdF        (trdF),
    .req_floor   (req_floor),
    .pending     (pending),
    .door_open   (door_open),
    .busy        (busy),
    .floor_err   (floor_err),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Word layout: {state, req_floor, pending, door_open, busy, floor_err, timeout_err}
  function automatic logic [11:0] w(input logic [1:0] st, input logic [1:0] req,
                                    input logic [3:0] pd, input logic door,
                                    input logic bsy, input logic ferr, input logic terr);
    return {st, req, pd, door, bsy, ferr, terr};
  endfunction

  function automatic logic [11:0] obs();
    return {state_dbg, req_floor, pending, door_open, busy, floor_err, timeout_err};
  endfunction

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic expect_o(input string tag, input logic [11:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic step(input logic [3:0] btn, input logic [3:0] fl);
    call_btn = btn;
    {trdF, sndF, fstF, gndF} = fl;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) check_eq(tag_q.pop_front(), obs(), exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b0;
    call_btn = 4'b0000;
    {trdF, sndF, fstF, gndF} = 4'b0001;
    #12;
    check_eq("reset_vals", obs(), 12'h000);
    rst = 1'b1;

    // Ground floor, call to floor 3
    expect_o("s1_latch", w(I, 2'd3 & 2'd0, 4'b1000, 0, 0, 0, 0)); step(4'b1000, 4'b0001);
    expect_o("s1_issue", w(M, 2'd3, 4'b1000, 0, 1, 0, 0));        step(4'b0000, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      expect_o("s1_dwell", w(D, 2'd3, 4'b0000, 1, 1, 0, 0));      step(4'b0000, 4'b1000);
    end
    expect_o("s1_idle", w(I, 2'd3, 4'b0000, 0, 0, 0, 0));         step(4'b0000, 4'b1000);

    // Floor 1 going up with calls at 0 and 3
    expect_o("s2_idle_f1", w(I, 2'd3, 4'b0000, 0, 0, 0, 0));      step(4'b0000, 4'b0010);
    expect_o("s2_latch", w(I, 2'd3, 4'b1001, 0, 0, 0, 0));        step(4'b1001, 4'b0010);
    expect_o("s2_up_first", w(M, 2'd3, 4'b1001, 0, 1, 0, 0));     step(4'b0000, 4'b0010);
    expect_o("s2_pass_f2", w(M, 2'd3, 4'b1001, 0, 1, 0, 0));      step(4'b0000, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      expect_o("s2_dwell3", w(D, 2'd3, 4'b0001, 1, 1, 0, 0));     step(4'b0000, 4'b1000);
    end
    expect_o("s2_idle3", w(I, 2'd3, 4'b0001, 0, 0, 0, 0));        step(4'b0000, 4'b1000);
    expect_o("s2_down_next", w(M, 2'd0, 4'b0001, 0, 1, 0, 0));    step(4'b0000, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      expect_o("s2_dwell0", w(D, 2'd0, 4'b0000, 1, 1, 0, 0));     step(4'b0000, 4'b0001);
    end
    expect_o("s2_idle0", w(I, 2'd0, 4'b0000, 0, 0, 0, 0));        step(4'b0000, 4'b0001);

    // Presses during a dwell at floor 2
    expect_o("s3_latch", w(I, 2'd0, 4'b0100, 0, 0, 0, 0));        step(4'b0100, 4'b0001);
    expect_o("s3_issue", w(M, 2'd2, 4'b0100, 0, 1, 0, 0));        step(4'b0000, 4'b0001);
    expect_o("s3_arrive", w(D, 2'd2, 4'b0000, 1, 1, 0, 0));       step(4'b0000, 4'b0100);
    expect_o("s3_ignore_cf", w(D, 2'd2, 4'b0000, 1, 1, 0, 0));    step(4'b0100, 4'b0100);
    expect_o("s3_latch_other", w(D, 2'd2, 4'b0001, 1, 1, 0, 0));  step(4'b0101, 4'b0100);
    expect_o("s3_dwell_end", w(D, 2'd2, 4'b0001, 1, 1, 0, 0));    step(4'b0000, 4'b0100);
    expect_o("s3_idle", w(I, 2'd2, 4'b0001, 0, 0, 0, 0));         step(4'b0000, 4'b0100);
    expect_o("s3_serve0", w(M, 2'd0, 4'b0001, 0, 1, 0, 0));       step(4'b0000, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      expect_o("s3_dwell0", w(D, 2'd0, 4'b0000, 1, 1, 0, 0));     step(4'b0000, 4'b0001);
    end
    expect_o("s3_idle0", w(I, 2'd0, 4'b0000, 0, 0, 0, 0));        step(4'b0000, 4'b0001);

    // Lift stuck at ground while moving to floor 3
    expect_o("s4_latch", w(I, 2'd0, 4'b1000, 0, 0, 0, 0));        step(4'b1000, 4'b0001);
    expect_o("s4_issue", w(M, 2'd3, 4'b1000, 0, 1, 0, 0));        step(4'b0000, 4'b0001);
    for (int k = 0; k < 15; k++) begin
      expect_o("s4_moving", w(M, 2'd3, 4'b1000, 0, 1, 0, 0));     step(4'b0000, 4'b0001);
    end
    expect_o("s4_timeout", w(I, 2'd3, 4'b1000, 0, 0, 0, 1));      step(4'b0000, 4'b0001);
    expect_o("s4_reissue", w(M, 2'd3, 4'b1000, 0, 1, 0, 0));      step(4'b0000, 4'b0001);

    // Corrupt floor indicators mid-move
    expect_o("s5_ferr", w(M, 2'd3, 4'b1000, 0, 1, 1, 0));         step(4'b0000, 4'b0011);
    expect_o("s5_latch_in_err", w(M, 2'd3, 4'b1100, 0, 1, 1, 0)); step(4'b0100, 4'b0011);
    expect_o("s5_no_arrive", w(M, 2'd3, 4'b1100, 0, 1, 1, 0));    step(4'b0000, 4'b1001);
    expect_o("s5_resume", w(D, 2'd3, 4'b0100, 1, 1, 0, 0));       step(4'b0000, 4'b1000);
    for (int k = 0; k < 3; k++) begin
      expect_o("s5_dwell3", w(D, 2'd3, 4'b0100, 1, 1, 0, 0));     step(4'b0000, 4'b1000);
    end
    expect_o("s5_idle3", w(I, 2'd3, 4'b0100, 0, 0, 0, 0));        step(4'b0000, 4'b1000);

    // Asynchronous reset in the middle of a move
    expect_o("s6_move_0110", w(M, 2'd2, 4'b0110, 0, 1, 0, 0));    step(4'b0010, 4'b1000);
    expect_o("s6_moving", w(M, 2'd2, 4'b0110, 0, 1, 0, 0));       step(4'b0000, 4'b1000);
    #2;
    rst = 1'b0;
    #1;
    check_eq("s6_async_rst", obs(), 12'h000);
    #3;
    rst = 1'b1;
    expect_o("s6_after_rst", w(I, 2'd0, 4'b0000, 0, 0, 0, 0));    step(4'b0000, 4'b0010);
    expect_o("s6_latch", w(I, 2'd0, 4'b1001, 0, 0, 0, 0));        step(4'b1001, 4'b0010);
    expect_o("s6_dir_up", w(M, 2'd3, 4'b1001, 0, 1, 0, 0));       step(4'b0000, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lift_call_scheduler.md
Name: lift_call_scheduler

Overview:
- Request side of the lift controller interface.
- Collects floor call-button presses for floors 0..3 into a pending set.
- Picks the next floor with a direction-preserving (SCAN) rule and drives the lift's 2-bit requested-floor input.
- Watches the lift's one-hot floor indicators to detect arrival, then clears the call and holds a door dwell before issuing the next request.

Parameters:
- DWELL_CYCLES, 4: clock cycles door_open stays high after an arrival; legal range 1..255.
- TIMEOUT_CYCLES, 16: clock cycles allowed in MOVE before arrival is declared failed; legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- call_btn  input  4  level call buttons; bit n = floor n (0 = ground, 3 = third).
- gndF  input  1  lift at floor 0.
- fstF  input  1  lift at floor 1.
- sndF  input  1  lift at floor 2.
- trdF  input  1  lift at floor 3.
- req_floor  output  2  requested floor, connected to the lift's datain.
- pending  output  4  latched outstanding calls (button lamps).
- door_open  output  1  high during dwell.
- busy  output  1  high when state is not IDLE.
- floor_err  output  1  floor indicators are not exactly one-hot this cycle (registered).
- timeout_err  output  1  one-cycle pulse when a MOVE times out.

Behaviour:
- Reset values (rst=0, asynchronous):
  - req_floor=0, pending=0, door_open=0, busy=0, floor_err=0, timeout_err=0.
  - state=IDLE, dir=UP, counters=0.
- Current floor cf is the binary encoding of {trdF,sndF,fstF,gndF}.
- Valid indicators: exactly one bit set. Otherwise floor_err=1 next cycle, no state transition that cycle, and pending still latches presses.
- Latching: each cycle pending[n] is set to 1 where call_btn[n]=1. A clear of the same bit in the same cycle wins. A held button re-latches the cycle after the clear, except as stated for DWELL.
- SCAN select, from cf and dir:
  - dir=UP: lowest pending floor > cf; if none, dir:=DOWN and take the highest pending floor < cf.
  - dir=DOWN: mirror of UP.
  - The bit pending[cf] is excluded from selection; IDLE handles it directly.
- States:
  - IDLE:
    - If pending[cf]=1: clear it, go to DWELL.
    - Else if pending≠0: req_floor:=selected target, load timeout counter, go to MOVE.
    - Else stay; req_floor holds its last value.
  - MOVE:
    - req_floor is held constant; it is never changed mid-move.
    - When indicators are valid and cf==req_floor: clear pending[req_floor], go to DWELL.
    - Timeout counter decrements each cycle. At 0 with no arrival: one-cycle timeout_err pulse, go to IDLE with pending retained. The next IDLE reselects from the then-current cf.
  - DWELL:
    - door_open=1 for exactly DWELL_CYCLES cycles, then go to IDLE.
    - call_btn[cf] is ignored during DWELL; other floors latch.
- busy=1 in MOVE and DWELL.
- Latency:
  - Button press to pending bit: 1 cycle.
  - pending to req_floor update from IDLE: 1 cycle.
  - Arrival to door_open: 1 cycle.
- Reset mid-MOVE or mid-DWELL: all outputs return immediately to reset values and all pending calls are lost.

Test Plan:
- Idle at floor 0 (gndF=1), pulse call_btn=4'b1000 for 1 cycle:
  - pending=1000 next cycle.
  - req_floor=3, busy=1 the cycle after.
  - Drive trdF=1 only → pending=0000 and door_open=1 for 4 cycles, then busy=0.
- Lift at floor 1, dir=UP, calls 4'b1001 latched together → req_floor=3 first. After arrival and dwell: dir=DOWN, req_floor=0.
- Press call_btn[2] while in DWELL at floor 2:
  - pending[2] stays 0.
  - Press call_btn[0] during the same dwell → pending=0001, served after dwell.
- In MOVE to floor 3, hold gndF=1 for 16 cycles:
  - timeout_err pulses once.
  - state returns to IDLE, pending[3] still 1, a new MOVE is issued.
- Drive gndF=fstF=1 with a pending call: floor_err=1, state does not advance, req_floor unchanged; restoring one-hot resumes.
- Deassert-then-assert rst (rst=0) mid-MOVE with pending=0110: outputs go to reset values asynchronously, pending=0000, req_floor=0.
